// File: rtl/write_back_if.sv
// ---------------------------------------------------------------------------
// write_back_if
// Bundle between the memory stage / decode and the write-back stage.
//   master : memory stage + decode side (drives commit bundle and read
//            addresses, receives read data, counters and commit strobes)
//   slave  : write_back (consumes commit bundle, serves read ports)
// Signals:
//   interlock, pc                      stall and bundle PC
//   u_/l_ valid, rt, rt_flag, is_load, alu_res   per-lane commit info
//   mem_douta / mem_doutb              load data for u / l lanes
//   ra0..ra3 -> rd0..rd3               write-first register read ports
//   retired_count, last_pc             retirement bookkeeping
//   wb_u_we/wb_l_we, wb_u_data/wb_l_data  effective commits for forwarding
// ---------------------------------------------------------------------------
interface write_back_if #(
    parameter int DATA_W = 32
);
    logic              interlock;
    logic [31:0]       pc;
    logic              u_valid;
    logic              l_valid;
    logic [4:0]        u_rt;
    logic [4:0]        l_rt;
    logic              u_rt_flag;
    logic              l_rt_flag;
    logic              u_is_load;
    logic              l_is_load;
    logic [DATA_W-1:0] u_alu_res;
    logic [DATA_W-1:0] l_alu_res;
    logic [DATA_W-1:0] mem_douta;
    logic [DATA_W-1:0] mem_doutb;
    logic [4:0]        ra0;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [4:0]        ra3;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rd3;
    logic [31:0]       retired_count;
    logic [31:0]       last_pc;
    logic              wb_u_we;
    logic              wb_l_we;
    logic [DATA_W-1:0] wb_u_data;
    logic [DATA_W-1:0] wb_l_data;

    modport master (
        output interlock, pc,
        output u_valid, l_valid, u_rt, l_rt, u_rt_flag, l_rt_flag,
        output u_is_load, l_is_load, u_alu_res, l_alu_res,
        output mem_douta, mem_doutb,
        output ra0, ra1, ra2, ra3,
        input  rd0, rd1, rd2, rd3,
        input  retired_count, last_pc,
        input  wb_u_we, wb_l_we, wb_u_data, wb_l_data
    );

    modport slave (
        input  interlock, pc,
        input  u_valid, l_valid, u_rt, l_rt, u_rt_flag, l_rt_flag,
        input  u_is_load, l_is_load, u_alu_res, l_alu_res,
        input  mem_douta, mem_doutb,
        input  ra0, ra1, ra2, ra3,
        output rd0, rd1, rd2, rd3,
        output retired_count, last_pc,
        output wb_u_we, wb_l_we, wb_u_data, wb_l_data
    );
endinterface

// File: rtl/write_back.sv
// ---------------------------------------------------------------------------
// write_back
// Final stage of the two-lane (u/l) core. Picks load data or ALU result per
// lane, commits up to two results per cycle into the general register file,
// serves four write-first read ports, and tracks retired-instruction count
// and last retired PC.
// Ports:
//   clk   clock, all state updates on posedge
//   rstn  asynchronous reset, active-high (1 = reset)
//   wb    write_back_if.slave: commit bundle, read ports, bookkeeping and
//         effective commit strobes (see write_back_if)
// ---------------------------------------------------------------------------
module write_back #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic         clk,
    input  logic         rstn,
    write_back_if.slave  wb
);

    logic [DATA_W-1:0] gpr_q [REG_NUM];
    logic [31:0]       retired_cnt_q;
    logic [31:0]       last_pc_q;

    logic [DATA_W-1:0] data_u;
    logic [DATA_W-1:0] data_l;
    logic              we_u;
    logic              we_l;

    // Write-first read: the l lane is program-later, so it is checked first.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [4:0]        ra,
        input logic [DATA_W-1:0] stored,
        input logic              wel,
        input logic [4:0]        rtl,
        input logic [DATA_W-1:0] dl,
        input logic              weu,
        input logic [4:0]        rtu,
        input logic [DATA_W-1:0] du
    );
        logic [DATA_W-1:0] r;
        if (ra == 5'd0)
            r = '0;
        else if (wel && (rtl == ra))
            r = dl;
        else if (weu && (rtu == ra))
            r = du;
        else
            r = stored;
        return r;
    endfunction

    always_comb begin
        data_u = wb.u_is_load ? wb.mem_douta : wb.u_alu_res;
        data_l = wb.l_is_load ? wb.mem_doutb : wb.l_alu_res;
        // Reset is folded in so a commit coinciding with reset never bypasses.
        we_u = wb.u_valid & wb.u_rt_flag & (wb.u_rt != 5'd0) & ~wb.interlock & ~rstn;
        we_l = wb.l_valid & wb.l_rt_flag & (wb.l_rt != 5'd0) & ~wb.interlock & ~rstn;
    end

    assign wb.wb_u_we   = we_u;
    assign wb.wb_l_we   = we_l;
    assign wb.wb_u_data = data_u;
    assign wb.wb_l_data = data_l;

    assign wb.rd0 = rd_sel(wb.ra0, gpr_q[wb.ra0], we_l, wb.l_rt, data_l, we_u, wb.u_rt, data_u);
    assign wb.rd1 = rd_sel(wb.ra1, gpr_q[wb.ra1], we_l, wb.l_rt, data_l, we_u, wb.u_rt, data_u);
    assign wb.rd2 = rd_sel(wb.ra2, gpr_q[wb.ra2], we_l, wb.l_rt, data_l, we_u, wb.u_rt, data_u);
    assign wb.rd3 = rd_sel(wb.ra3, gpr_q[wb.ra3], we_l, wb.l_rt, data_l, we_u, wb.u_rt, data_u);

    assign wb.retired_count = retired_cnt_q;
    assign wb.last_pc       = last_pc_q;

    // Commit boundary: register file and retirement state.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < REG_NUM; i++)
                gpr_q[i] <= '0;
            retired_cnt_q <= '0;
            last_pc_q     <= '0;
        end else begin
            // u first, then l: on a same-register conflict the later
            // non-blocking assignment (l lane) is the one that lands.
            if (we_u)
                gpr_q[wb.u_rt] <= data_u;
            if (we_l)
                gpr_q[wb.l_rt] <= data_l;
            if (!wb.interlock) begin
                // Stores/branches (no rt_flag) still retire and count.
                retired_cnt_q <= retired_cnt_q + {31'd0, wb.u_valid} + {31'd0, wb.l_valid};
                if (wb.u_valid || wb.l_valid)
                    last_pc_q <= wb.pc;
            end
        end
    end

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    write_back_if #(.DATA_W(32)) bus();

    write_back #(.DATA_W(32), .REG_NUM(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .wb   (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Behavioural model: architectural register image plus counters.
    logic [31:0] m_gpr [32];
    logic [31:0] m_cnt;
    logic [31:0] m_pc;

    function automatic logic [31:0] m_data_u();
        return bus.u_is_load ? bus.mem_douta : bus.u_alu_res;
    endfunction

    function automatic logic [31:0] m_data_l();
        return bus.l_is_load ? bus.mem_doutb : bus.l_alu_res;
    endfunction

    function automatic logic m_we_u();
        return bus.u_valid && bus.u_rt_flag && (bus.u_rt != 0) && !bus.interlock && !rstn;
    endfunction

    function automatic logic m_we_l();
        return bus.l_valid && bus.l_rt_flag && (bus.l_rt != 0) && !bus.interlock && !rstn;
    endfunction

    // Expected read = the register image as it will look after this cycle's
    // commits (u applied, then l on top), register 0 pinned to zero.
    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        logic [31:0] img [32];
        img = m_gpr;
        if (m_we_u()) img[bus.u_rt] = m_data_u();
        if (m_we_l()) img[bus.l_rt] = m_data_l();
        img[0] = 32'd0;
        return img[ra];
    endfunction

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_cnt = 32'd0;
            m_pc  = 32'd0;
        end else if (!bus.interlock) begin
            if (m_we_u()) m_gpr[bus.u_rt] = m_data_u();
            if (m_we_l()) m_gpr[bus.l_rt] = m_data_l();
            m_cnt = m_cnt + 32'(bus.u_valid) + 32'(bus.l_valid);
            if (bus.u_valid || bus.l_valid) m_pc = bus.pc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        chk("rd0", bus.rd0, m_rd(bus.ra0));
        chk("rd1", bus.rd1, m_rd(bus.ra1));
        chk("rd2", bus.rd2, m_rd(bus.ra2));
        chk("rd3", bus.rd3, m_rd(bus.ra3));
        chk("wb_u_we", 32'(bus.wb_u_we), 32'(m_we_u()));
        chk("wb_l_we", 32'(bus.wb_l_we), 32'(m_we_l()));
        chk("wb_u_data", bus.wb_u_data, m_data_u());
        chk("wb_l_data", bus.wb_l_data, m_data_l());
        chk("retired_count", bus.retired_count, m_cnt);
        chk("last_pc", bus.last_pc, m_pc);
    end

    task automatic clr();
        bus.interlock = 1'b0;
        bus.u_valid   = 1'b0; bus.l_valid   = 1'b0;
        bus.u_rt      = 5'd0; bus.l_rt      = 5'd0;
        bus.u_rt_flag = 1'b0; bus.l_rt_flag = 1'b0;
        bus.u_is_load = 1'b0; bus.l_is_load = 1'b0;
        bus.u_alu_res = 32'd0; bus.l_alu_res = 32'd0;
        bus.mem_douta = 32'd0; bus.mem_doutb = 32'd0;
    endtask

    task automatic set_u(input logic [4:0] rt, input logic flag, input logic ld,
                         input logic [31:0] alu, input logic [31:0] mem);
        bus.u_valid = 1'b1; bus.u_rt = rt; bus.u_rt_flag = flag;
        bus.u_is_load = ld; bus.u_alu_res = alu; bus.mem_douta = mem;
    endtask

    task automatic set_l(input logic [4:0] rt, input logic flag, input logic ld,
                         input logic [31:0] alu, input logic [31:0] mem);
        bus.l_valid = 1'b1; bus.l_rt = rt; bus.l_rt_flag = flag;
        bus.l_is_load = ld; bus.l_alu_res = alu; bus.mem_doutb = mem;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        clr();
        bus.pc = 32'd0;
        bus.ra0 = 5'd0; bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.ra3 = 5'd0;
        #1 rstn = 1'b1;
        mid();
        chk("reset_count", bus.retired_count, 32'd0);
        chk("reset_pc", bus.last_pc, 32'd0);
        tick();
        rstn = 1'b0;

        // Dual commit: u ALU -> r5, l load -> r6.
        bus.pc = 32'h100;
        set_u(5'd5, 1'b1, 1'b0, 32'h11111111, 32'hDEADBEEF);
        set_l(5'd6, 1'b1, 1'b1, 32'h33333333, 32'h22222222);
        bus.ra0 = 5'd5; bus.ra1 = 5'd6; bus.ra2 = 5'd0; bus.ra3 = 5'd7;
        mid();
        chk("dual_bypass_u", bus.rd0, 32'h11111111);
        chk("dual_bypass_l", bus.rd1, 32'h22222222);
        chk("dual_we_u", 32'(bus.wb_u_we), 32'd1);
        tick();
        chk("dual_count", bus.retired_count, 32'd2);
        chk("dual_pc", bus.last_pc, 32'h100);
        clr();
        mid();
        chk("dual_gpr_u", bus.rd0, 32'h11111111);
        chk("dual_gpr_l", bus.rd1, 32'h22222222);
        tick();

        // Same-register conflict: l lane wins.
        bus.pc = 32'h104;
        set_u(5'd7, 1'b1, 1'b0, 32'hAAAA0000, 32'd0);
        set_l(5'd7, 1'b1, 1'b0, 32'h0000BBBB, 32'd0);
        mid();
        chk("conflict_bypass", bus.rd3, 32'h0000BBBB);
        tick();
        clr();
        mid();
        chk("conflict_gpr", bus.rd3, 32'h0000BBBB);
        chk("conflict_count", bus.retired_count, 32'd4);
        tick();

        // Both lanes target r0.
        bus.pc = 32'h108;
        set_u(5'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0);
        set_l(5'd0, 1'b1, 1'b1, 32'd0, 32'hFFFFFFFF);
        mid();
        chk("r0_rd", bus.rd2, 32'd0);
        chk("r0_we_u", 32'(bus.wb_u_we), 32'd0);
        chk("r0_we_l", 32'(bus.wb_l_we), 32'd0);
        tick();
        chk("r0_count", bus.retired_count, 32'd6);
        clr();

        // Interlock held for 3 cycles with writes to r3.
        bus.pc = 32'h10C;
        bus.ra2 = 5'd3;
        set_u(5'd3, 1'b1, 1'b0, 32'h12345678, 32'd0);
        set_l(5'd9, 1'b1, 1'b0, 32'h00009999, 32'd0);
        bus.interlock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ilk_rd", bus.rd2, 32'd0);
            chk("ilk_we", 32'(bus.wb_u_we), 32'd0);
            tick();
            chk("ilk_count", bus.retired_count, 32'd6);
            chk("ilk_pc", bus.last_pc, 32'h108);
        end
        bus.interlock = 1'b0;
        mid();
        chk("ilk_rel_bypass", bus.rd2, 32'h12345678);
        tick();
        chk("ilk_rel_count", bus.retired_count, 32'd8);
        chk("ilk_rel_pc", bus.last_pc, 32'h10C);
        clr();

        // Store-only bundle: counts, writes nothing.
        bus.pc = 32'h110;
        bus.ra1 = 5'd4;
        set_u(5'd4, 1'b0, 1'b0, 32'h00004444, 32'd0);
        mid();
        chk("store_we", 32'(bus.wb_u_we), 32'd0);
        tick();
        chk("store_count", bus.retired_count, 32'd9);
        chk("store_pc", bus.last_pc, 32'h110);
        clr();
        mid();
        chk("store_rd", bus.rd1, 32'd0);

        // Counter wrap from 0xFFFFFFFF.
        force dut.retired_cnt_q = 32'hFFFFFFFF;
        m_cnt = 32'hFFFFFFFF;
        #1 release dut.retired_cnt_q;
        #1 chk("wrap_pre", bus.retired_count, 32'hFFFFFFFF);
        tick();
        bus.pc = 32'h114;
        set_u(5'd10, 1'b1, 1'b0, 32'h0000000A, 32'd0);
        tick();
        chk("wrap_count", bus.retired_count, 32'd0);
        chk("wrap_pc", bus.last_pc, 32'h114);
        clr();

        // Asynchronous reset mid-cycle while a dual commit is pending.
        bus.pc = 32'h118;
        set_u(5'd11, 1'b1, 1'b0, 32'h00000055, 32'd0);
        set_l(5'd12, 1'b1, 1'b0, 32'h00000066, 32'd0);
        bus.ra0 = 5'd5; bus.ra1 = 5'd6; bus.ra2 = 5'd7; bus.ra3 = 5'd11;
        #2 rstn = 1'b1;
        #1;
        chk("arst_rd0", bus.rd0, 32'd0);
        chk("arst_rd1", bus.rd1, 32'd0);
        chk("arst_rd2", bus.rd2, 32'd0);
        chk("arst_rd3", bus.rd3, 32'd0);
        chk("arst_count", bus.retired_count, 32'd0);
        chk("arst_pc", bus.last_pc, 32'd0);
        chk("arst_we", 32'(bus.wb_u_we), 32'd0);
        tick();
        rstn = 1'b0;
        clr();
        bus.ra2 = 5'd12;
        mid();
        chk("arst_discard_u", bus.rd3, 32'd0);
        chk("arst_discard_l", bus.rd2, 32'd0);
        chk("arst_count2", bus.retired_count, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage of the two-lane (u/l) core. Sits directly downstream of the memory stage and consumes its registered outputs: per-lane destination register, the load data words mem_douta/mem_doutb, plus the ALU results carried alongside. Selects load data or ALU result per lane, commits up to two results per cycle into the 32-entry general register file, and serves four write-first read ports to decode. Also tracks retired-instruction count and last retired PC.

## Interface
- DATA_W, 32, register/data width
- REG_NUM, 32, register count; register 0 reads as zero
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  reset; asynchronous, active-high (1 = reset)
- interlock  in  1  pipeline stall; 1 = no commit, no state change
- pc  in  32  PC of the bundle in this stage
- u_valid, l_valid  in  1 each  lane holds a real instruction (0 = bubble)
- u_rt, l_rt  in  5 each  destination register per lane
- u_rt_flag, l_rt_flag  in  1 each  lane writes its rt
- u_is_load, l_is_load  in  1 each  result comes from memory, not ALU
- u_alu_res, l_alu_res  in  DATA_W each  ALU result per lane
- mem_douta, mem_doutb  in  DATA_W each  load data for u and l lanes
- ra0..ra3  in  5 each  read addresses from decode
- rd0..rd3  out  DATA_W each  read data (combinational)
- retired_count  out  32  committed instruction count
- last_pc  out  32  PC of most recent committing bundle
- wb_u_we, wb_l_we  out  1 each  effective commit strobes (for forwarding/scoreboard)
- wb_u_data, wb_l_data  out  DATA_W each  selected result per lane

## Operation
- Lane result: data_x = x_is_load ? mem_dout(a|b) : x_alu_res (u↔a, l↔b).
- Effective write enable: we_x = x_valid & x_rt_flag & (x_rt != 0) & ~interlock & ~rstn.
- Commit on posedge clk: if we_u, gpr[u_rt] <= data_u; if we_l, gpr[l_rt] <= data_l.
- Same-register conflict (we_u & we_l & u_rt == l_rt): l lane (program-later) wins; only data_l is written.
- Register 0: never written; reads return 0 regardless of bypass.
- Read ports, write-first: rdN = 0 if raN==0; else data_l if we_l & l_rt==raN; else data_u if we_u & u_rt==raN; else gpr[raN]. l checked before u.
- retired_count += (u_valid & ~interlock) + (l_valid & ~interlock); valid lanes without rt_flag (stores, branches) still count; 32-bit wrap from 0xFFFFFFFF.
- last_pc <= pc when ~interlock & (u_valid | l_valid).
- wb_x_we = we_x, wb_x_data = data_x, combinational, for the hazard unit.
- Interlock: gpr, retired_count, last_pc hold; wb_*_we forced 0; read ports return stored values only.

## Timing
- Reset (rstn=1, asynchronous): all gpr entries 0, retired_count 0, last_pc 0 immediately; no commit while asserted; released synchronously to next posedge.
- Reset mid-commit: a write in the same cycle as reset assertion is discarded.
- Commit latency: value visible on rdN combinationally in the commit cycle (bypass), from gpr on the cycle after.
- Read data purely combinational from ra/commit inputs; no read latency.
- Inputs are registered in memory stage; this block adds no pipeline register on the data path.
- retired_count/last_pc update on the same posedge as the commit.

## Test plan
- Reset: drive writes then assert rstn asynchronously mid-cycle -> rd0..rd3 read 0 for all addresses, retired_count=0, last_pc=0 without waiting for clk.
- Dual commit: u writes r5 ALU=0x11111111, l writes r6 load mem_doutb=0x22222222 -> same cycle rd0(ra=5)=0x11111111, rd1(ra=6)=0x22222222 via bypass; next cycle from gpr; retired_count +2.
- Conflict: u_rt=l_rt=7, u data 0xAAAA0000, l data 0x0000BBBB -> r7=0x0000BBBB, bypass read of 7 returns 0x0000BBBB.
- r0: both lanes write r0 with 0xFFFFFFFF -> rdN(ra=0)=0, wb_*_we=0, retired_count still +2.
- Interlock: hold interlock=1 with valid writes to r3 for 3 cycles -> r3 unchanged, retired_count and last_pc unchanged; release -> single commit, count +2.
- Counter wrap: preload via 0xFFFFFFFF commits (or force) then commit one u-only bundle -> retired_count=0x00000000; store-only bundle (rt_flag=0) increments count, writes nothing.
